// File: rtl/score_keeper_pkg.sv
// Shared types and widths for the score keeper and the display stage.
package score_keeper_pkg;

    // Score width shared with the binary-to-BCD display conversion.
    localparam int SCORE_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PLAYING   = 2'b01,
        ST_GAME_OVER = 2'b10
    } game_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

endpackage

// File: rtl/score_keeper_if.sv
// Player buttons, game control and score outputs of the score keeper.
interface score_keeper_if;
    import score_keeper_pkg::*;

    logic               btn1_n;
    logic               btn2_n;
    logic               start;
    logic               clear;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               game_over;
    logic [1:0]         winner;
    logic [1:0]         point_pulse;

    // Stimulus side: drives buttons and control, observes scores.
    modport master (
        output btn1_n, btn2_n, start, clear,
        input  score1, score2, game_over, winner, point_pulse
    );

    // Score keeper side.
    modport slave (
        input  btn1_n, btn2_n, start, clear,
        output score1, score2, game_over, winner, point_pulse
    );

endinterface

// File: rtl/score_keeper_button_debounce.sv
// Synchronizes one raw active-low button, debounces it and emits a
// one-cycle strobe on each accepted press. Releases produce nothing.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             filt;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer; idles at released (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= btn_n;
            sync_p1 <= sync_p0;
        end
    end

    // Stability counter: the filtered level follows the synchronized level
    // only after the two have disagreed long enough; a press strobe fires
    // on the released->pressed change of the filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt  <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_p1 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                filt  <= sync_p1;
                cnt   <= '0;
                press <= ~sync_p1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Two-player point counter: debounced buttons feed a game FSM that keeps
// both scores, detects the winner and strobes each accepted point.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIN_SCORE       = 15,
    parameter int MAX_SCORE       = 999
) (
    input  logic              clk,
    input  logic              rst_n,
    score_keeper_if.slave     ifc
);

    logic               press1;
    logic               press2;

    game_state_t        state;
    logic [SCORE_W-1:0] score1_q;
    logic [SCORE_W-1:0] score2_q;
    logic               game_over_q;
    winner_t            winner_q;
    logic [1:0]         point_pulse_q;

    logic [SCORE_W-1:0] next1;
    logic [SCORE_W-1:0] next2;
    logic               hit1;
    logic               hit2;

    // Increment that sticks at the display ceiling instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        if (s >= SCORE_W'(MAX_SCORE))
            return SCORE_W'(MAX_SCORE);
        else
            return s + SCORE_W'(1);
    endfunction

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (ifc.btn1_n),
        .press (press1)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (ifc.btn2_n),
        .press (press2)
    );

    // Candidate scores for this cycle's strobes and whether each hits the win score.
    always_comb begin
        next1 = score1_q;
        next2 = score2_q;
        hit1  = 1'b0;
        hit2  = 1'b0;
        if (press1) begin
            next1 = sat_inc(score1_q);
            hit1  = (next1 == SCORE_W'(WIN_SCORE));
        end
        if (press2) begin
            next2 = sat_inc(score2_q);
            hit2  = (next2 == SCORE_W'(WIN_SCORE));
        end
    end

    // Game FSM with registered outputs; clear outranks start, start outranks presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            score1_q      <= '0;
            score2_q      <= '0;
            game_over_q   <= 1'b0;
            winner_q      <= WIN_NONE;
            point_pulse_q <= 2'b00;
        end else begin
            point_pulse_q <= 2'b00;
            if (ifc.clear) begin
                state       <= ST_IDLE;
                score1_q    <= '0;
                score2_q    <= '0;
                game_over_q <= 1'b0;
                winner_q    <= WIN_NONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ifc.start) begin
                            state    <= ST_PLAYING;
                            score1_q <= '0;
                            score2_q <= '0;
                        end
                    end
                    ST_PLAYING: begin
                        score1_q      <= next1;
                        score2_q      <= next2;
                        point_pulse_q <= {press2, press1};
                        if (hit1 || hit2) begin
                            state       <= ST_GAME_OVER;
                            game_over_q <= 1'b1;
                            if (hit1 && hit2)
                                winner_q <= WIN_DRAW;
                            else if (hit1)
                                winner_q <= WIN_P1;
                            else
                                winner_q <= WIN_P2;
                        end
                    end
                    ST_GAME_OVER: begin
                        if (ifc.start) begin
                            state       <= ST_PLAYING;
                            score1_q    <= '0;
                            score2_q    <= '0;
                            game_over_q <= 1'b0;
                            winner_q    <= WIN_NONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ifc.score1      = score1_q;
    assign ifc.score2      = score2_q;
    assign ifc.game_over   = game_over_q;
    assign ifc.winner      = winner_q;
    assign ifc.point_pulse = point_pulse_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a short debounce and a low win score.
module tb_score_keeper;
    import score_keeper_pkg::*;

    localparam int DEB = 4;
    localparam int WIN = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [1:0] pp;
    logic       saw_pp;

    score_keeper_if ifc ();

    score_keeper #(
        .DEBOUNCE_CYCLES (DEB),
        .WIN_SCORE       (WIN),
        .MAX_SCORE       (999)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the selected buttons long enough for one point, report the
    // point_pulse seen on the scoring edge, then release and let the filters settle.
    task automatic press(input logic b1, input logic b2, output logic [1:0] pulse);
        ifc.btn1_n = ~b1;
        ifc.btn2_n = ~b2;
        repeat (DEB + 4) tick();
        pulse = ifc.point_pulse;
        ifc.btn1_n = 1'b1;
        ifc.btn2_n = 1'b1;
        repeat (DEB + 4) tick();
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic pulse_clear();
        ifc.clear = 1'b1;
        tick();
        ifc.clear = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        ifc.btn1_n = 1'b1;
        ifc.btn2_n = 1'b1;
        ifc.start  = 1'b0;
        ifc.clear  = 1'b0;
        repeat (2) tick();
        check("rst_score1", ifc.score1, 0);
        check("rst_score2", ifc.score2, 0);
        check("rst_game_over", ifc.game_over, 0);
        check("rst_winner", ifc.winner, 0);
        check("rst_pp", ifc.point_pulse, 0);
        rst_n = 1'b1;
        tick();

        // 1: held button gives exactly one point, 7 edges after first low sample
        pulse_start();
        ifc.btn1_n = 1'b0;
        repeat (7) tick();
        check("t1_before_edge7", ifc.score1, 0);
        tick();
        check("t1_score1", ifc.score1, 1);
        check("t1_pp", ifc.point_pulse, 2'b01);
        check("t1_score2", ifc.score2, 0);
        tick();
        check("t1_pp_one_cycle", ifc.point_pulse, 2'b00);
        repeat (11) tick();
        check("t1_held_score1", ifc.score1, 1);
        ifc.btn1_n = 1'b1;
        repeat (DEB + 4) tick();

        // 2: short glitch on btn2 is rejected
        saw_pp = 1'b0;
        ifc.btn2_n = 1'b0;
        repeat (3) tick();
        ifc.btn2_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ifc.point_pulse != 2'b00) saw_pp = 1'b1;
        end
        check("t2_no_strobe", saw_pp, 0);
        check("t2_score2", ifc.score2, 0);

        // 3: simultaneous presses, both reach the win score -> draw
        pulse_clear();
        pulse_start();
        press(1'b1, 1'b1, pp);
        check("t3_pp1", pp, 2'b11);
        check("t3_s1_1", ifc.score1, 1);
        check("t3_s2_1", ifc.score2, 1);
        press(1'b1, 1'b1, pp);
        check("t3_s1_2", ifc.score1, 2);
        check("t3_s2_2", ifc.score2, 2);
        check("t3_go_mid", ifc.game_over, 0);
        press(1'b1, 1'b1, pp);
        check("t3_s1_3", ifc.score1, 3);
        check("t3_s2_3", ifc.score2, 3);
        check("t3_game_over", ifc.game_over, 1);
        check("t3_winner", ifc.winner, 2'b11);

        // 4: player 1 wins 3-1, presses frozen, start restarts
        pulse_start();
        check("t4_restart_s1", ifc.score1, 0);
        check("t4_restart_win", ifc.winner, 0);
        press(1'b1, 1'b0, pp);
        press(1'b0, 1'b1, pp);
        press(1'b1, 1'b0, pp);
        press(1'b1, 1'b0, pp);
        check("t4_s1", ifc.score1, 3);
        check("t4_s2", ifc.score2, 1);
        check("t4_winner", ifc.winner, 2'b01);
        check("t4_game_over", ifc.game_over, 1);
        press(1'b1, 1'b0, pp);
        check("t4_frozen_pp", pp, 2'b00);
        check("t4_frozen_s1", ifc.score1, 3);
        pulse_start();
        check("t4_start_s1", ifc.score1, 0);
        check("t4_start_s2", ifc.score2, 0);
        check("t4_start_win", ifc.winner, 0);
        check("t4_start_go", ifc.game_over, 0);
        press(1'b0, 1'b1, pp);
        check("t4_playing_s2", ifc.score2, 1);

        // 5: clear coincident with a press strobe discards it and goes IDLE
        press(1'b1, 1'b0, pp);
        press(1'b1, 1'b0, pp);
        check("t5_s1_pre", ifc.score1, 2);
        ifc.btn1_n = 1'b0;
        repeat (7) tick();
        ifc.clear = 1'b1;
        tick();
        ifc.clear = 1'b0;
        check("t5_clear_s1", ifc.score1, 0);
        check("t5_clear_s2", ifc.score2, 0);
        check("t5_clear_pp", ifc.point_pulse, 0);
        ifc.btn1_n = 1'b1;
        repeat (DEB + 4) tick();
        press(1'b1, 1'b0, pp);
        check("t5_idle_pp", pp, 0);
        check("t5_idle_s1", ifc.score1, 0);

        // 6: asynchronous reset mid-game and mid-debounce
        pulse_start();
        press(1'b1, 1'b0, pp);
        check("t6_s1_pre", ifc.score1, 1);
        ifc.btn1_n = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_s1", ifc.score1, 0);
        check("t6_rst_pp", ifc.point_pulse, 0);
        check("t6_rst_go", ifc.game_over, 0);
        check("t6_rst_win", ifc.winner, 0);
        ifc.btn1_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        press(1'b1, 1'b0, pp);
        check("t6_idle_pp", pp, 0);
        check("t6_idle_s1", ifc.score1, 0);
        check("t6_idle_s2", ifc.score2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
